// File: rtl/immed_enc.sv
// immed_enc: two-stage valid/ready encoder that packs an RV32 immediate and register fields into an instruction word.
// Optional macro IMMED_ENC_ERRCNT_EN adds a saturating error counter (err_cnt_o, err_clr_i).
// +----------------------------------------------------------------------+
// | Module   : immed_enc                                                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module immed_enc #(
   parameter int OUT_REG = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [2:0]  fmt_i,
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] inst_o,
   output logic        err_o
`ifdef IMMED_ENC_ERRCNT_EN
   ,
   output logic [15:0] err_cnt_o,
   input  logic        err_clr_i
`endif
);

   localparam logic [2:0] c_FMT_R = 3'd0;
   localparam logic [2:0] c_FMT_I = 3'd1;
   localparam logic [2:0] c_FMT_S = 3'd2;
   localparam logic [2:0] c_FMT_B = 3'd3;
   localparam logic [2:0] c_FMT_U = 3'd4;
   localparam logic [2:0] c_FMT_J = 3'd5;

   logic        r_s1_valid;
   logic [2:0]  r_s1_fmt;
   logic [6:0]  r_s1_op;
   logic [4:0]  r_s1_rd;
   logic [4:0]  r_s1_rs1;
   logic [4:0]  r_s1_rs2;
   logic [2:0]  r_s1_f3;
   logic [6:0]  r_s1_f7;
   logic [31:0] r_s1_imm;
   logic        r_s1_err;

   logic        w_s1_ready;
   logic        w_s2_ready;
   logic        w_sx11;
   logic        w_sx12;
   logic        w_sx20;
   logic        w_range_err;
   logic [31:0] w_pack;

   // An immediate fits n+1 signed bits when everything from bit n upward is a sign copy.
   assign w_sx11 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
   assign w_sx12 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
   assign w_sx20 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

   always_comb begin
      w_range_err = 1'b0;
      case (fmt_i)
         c_FMT_R: w_range_err = 1'b0;
         c_FMT_I,
         c_FMT_S: w_range_err = ~w_sx11;
         c_FMT_B: w_range_err = ~w_sx12 | imm_i[0];
         c_FMT_U: w_range_err = |imm_i[11:0];
         c_FMT_J: w_range_err = ~w_sx20 | imm_i[0];
         default: w_range_err = 1'b1;
      endcase
   end

   assign w_s1_ready = ~r_s1_valid | w_s2_ready;
   assign ready_o    = w_s1_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s1_valid <= 1'b0;
         r_s1_fmt   <= 3'd0;
         r_s1_op    <= 7'd0;
         r_s1_rd    <= 5'd0;
         r_s1_rs1   <= 5'd0;
         r_s1_rs2   <= 5'd0;
         r_s1_f3    <= 3'd0;
         r_s1_f7    <= 7'd0;
         r_s1_imm   <= 32'd0;
         r_s1_err   <= 1'b0;
      end else if (w_s1_ready) begin
         r_s1_valid <= valid_i;
         if (valid_i) begin
            r_s1_fmt <= fmt_i;
            r_s1_op  <= opcode_i;
            r_s1_rd  <= rd_i;
            r_s1_rs1 <= rs1_i;
            r_s1_rs2 <= rs2_i;
            r_s1_f3  <= funct3_i;
            r_s1_f7  <= funct7_i;
            r_s1_imm <= imm_i;
            r_s1_err <= w_range_err;
         end
      end
   end

   always_comb begin
      w_pack = 32'd0;
      case (r_s1_fmt)
         c_FMT_R: w_pack = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
         c_FMT_I: w_pack = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
         c_FMT_S: w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                            r_s1_imm[4:0], r_s1_op};
         c_FMT_B: w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                            r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
         c_FMT_U: w_pack = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
         c_FMT_J: w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                            r_s1_imm[19:12], r_s1_rd, r_s1_op};
         default: w_pack = 32'd0;
      endcase
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic        r_s2_valid;
         logic [31:0] r_s2_inst;
         logic        r_s2_err;

         assign w_s2_ready = ~r_s2_valid | ready_i;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_s2_valid <= 1'b0;
               r_s2_inst  <= 32'd0;
               r_s2_err   <= 1'b0;
            end else if (w_s2_ready) begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_inst <= w_pack;
                  r_s2_err  <= r_s1_err;
               end
            end
         end

         assign valid_o = r_s2_valid;
         assign inst_o  = r_s2_inst;
         assign err_o   = r_s2_err;
      end else begin : g_out_comb
         // Stage 1 registers reset to an R-format all-zero request, so outputs still reset to 0.
         assign w_s2_ready = ready_i;
         assign valid_o    = r_s1_valid;
         assign inst_o     = w_pack;
         assign err_o      = r_s1_err;
      end
   endgenerate

`ifdef IMMED_ENC_ERRCNT_EN
   logic [15:0] r_err_cnt;
   logic        w_out_fire;

   assign w_out_fire = valid_o & ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_cnt <= 16'd0;
      end else if (err_clr_i) begin
         r_err_cnt <= 16'd0;
      end else if (w_out_fire && err_o && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign err_cnt_o = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/immed_enc.md
Name: immed_enc

Overview:
Instruction encoder for RV32 immediates, the inverse of the core's immediate decode path. It accepts a format selector, a full 32-bit immediate and register/function fields, and packs them into a 32-bit instruction word. It flags immediates that the selected format cannot represent. The block serves the debug/patch path and the self-test instruction generator, and is a 2-stage valid/ready pipeline.

Parameters:
- OUT_REG, 1, 1 = stage-2 output registered (latency 2); 0 = stage 2 combinational from stage 1 (latency 1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  request valid
- ready_o  out  1  block can accept a request
- fmt_i  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- opcode_i  in  7  opcode field
- rd_i  in  5  destination register
- rs1_i  in  5  source register 1
- rs2_i  in  5  source register 2
- funct3_i  in  3  funct3 field
- funct7_i  in  7  funct7 field (R only)
- imm_i  in  32  byte-offset immediate, signed
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts the result
- inst_o  out  32  encoded instruction
- err_o  out  1  immediate not representable, or illegal fmt; qualified by valid_o

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: stage valids=0; valid_o=0, inst_o=0, err_o=0. ready_o=1 from the first cycle after reset release.
- Stage 1 (S1) registers the request and computes the range check. Stage 2 (S2) registers the packed word and the error.
- Handshake:
  - A transfer occurs when valid && ready.
  - Stage ready = !stage_valid | next_ready. ready_o = S1 ready.
  - Full throughput is 1 request per cycle with no bubbles under ready_i=1.
  - While valid_o=1 and ready_i=0: inst_o and err_o hold stable and valid_o stays 1. S1 fills, then ready_o drops.
  - Simultaneous S2 drain and S1 advance in the same cycle is allowed.
  - Latency: valid_i accepted at cycle N gives valid_o at N+2 (OUT_REG=1) or N+1 (OUT_REG=0).
- Range and error rules, applied to imm_i:
  - R: no check.
  - I and S: imm == sext(imm[11:0]).
  - B: imm == sext(imm[12:0]) and imm[0]==0.
  - U: imm[11:0]==0.
  - J: imm == sext(imm[20:0]) and imm[0]==0.
  - Illegal fmt (6,7): err_o=1 and inst_o=0.
- Packing, MSB to LSB:
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- On a range error the word is still packed from the truncated bits, and err_o=1.
- Fields unused by a format are ignored.
- Reset mid-operation: all in-flight requests are discarded. Outputs return to their reset values asynchronously.

Optional Feature:
- Macro: IMMED_ENC_ERRCNT_EN.
- Defined:
  - Adds output err_cnt_o [15:0], reset 0.
  - Increments on each output transfer (valid_o && ready_i) with err_o=1.
  - Saturates at 16'hFFFF.
  - Adds input err_clr_i [0:0], synchronous clear. If clear and increment occur in the same cycle, clear wins.
- Undefined: neither port exists, and no counter logic is generated.

Test Plan:
- Directed I: fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> inst_o=0x00500093, err_o=0, valid_o 2 cycles after accept.
- Directed S, J, U:
  - S, op=0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
  - J, op=0x6F, rd=1, imm=-4 -> 0xFFDFF0EF.
  - U, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- Errors:
  - B imm=3 -> err_o=1.
  - I imm=2048 -> err_o=1.
  - I imm=-2048 -> err_o=0, inst_o[31:20]=0x800.
  - fmt=7 -> err_o=1, inst_o=0.
- Backpressure: stream 4 back-to-back requests with ready_i=0 for 3 cycles:
  - ready_o drops once both stages are full.
  - Outputs stay stable during the stall.
  - All 4 results arrive in order with no loss or duplication.
- Reset: assert rst_ni low asynchronously with both stages full -> valid_o=0 immediately; no stale result appears after release.
- With IMMED_ENC_ERRCNT_EN: 3 error transfers -> err_cnt_o=3. err_clr_i and an error in the same cycle -> 0. Preload-to-saturation check holds at 0xFFFF.
